// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm fader slice: default widths and the fader FSM state type.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH     = 8;
  localparam int unsigned PWM_DIV_WIDTH = 16;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRamp = 1'b1
  } fader_state_e;

endpackage

// File: rtl/pwm_fader_if.sv
// Command channel of the pwm fader: target duty, step size and rate divider over valid/ready.
interface pwm_fader_if #(
  parameter int unsigned WIDTH     = pwm_pkg::PWM_WIDTH,
  parameter int unsigned DIV_WIDTH = pwm_pkg::PWM_DIV_WIDTH
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [WIDTH-1:0]     cmd_target;
  logic [WIDTH-1:0]     cmd_step;
  logic [DIV_WIDTH-1:0] cmd_div;

  modport master (
    output cmd_valid, cmd_target, cmd_step, cmd_div,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_step, cmd_div,
    output cmd_ready
  );

endinterface

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter plus the divider that turns period ends into update ticks.
module pwm_period_timer
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH     = PWM_WIDTH,
  parameter int unsigned DIV_WIDTH = PWM_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div_l,
  output logic                 period_tick,
  output logic                 update_tick
);

  logic [WIDTH-1:0]     pc_q;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;

  assign period_tick = &pc_q;
  assign update_tick = period_tick && (div_cnt_q == div_l);

  // A command accept restarts the divider so the first step waits a full div_l+1 periods.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear) begin
      div_cnt_d = '0;
    end else if (period_tick) begin
      div_cnt_d = (div_cnt_q == div_l) ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      div_cnt_q <= '0;
    end else begin
      pc_q      <= pc_q + 1'b1;
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_fader.sv
// Duty-cycle ramp generator feeding a pwm stage; duty moves one clamped step per update tick,
// and only on the edge that ends a PWM period.
module pwm_fader
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH     = PWM_WIDTH,
  parameter int unsigned DIV_WIDTH = PWM_DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  pwm_fader_if.slave       cmd,
  input  logic             abort,
  output logic [WIDTH-1:0] duty,
  output logic             busy,
  output logic             done,
  output logic             period_tick
);

  fader_state_e         state_q, state_d;
  logic [WIDTH-1:0]     duty_q, duty_d;
  logic [WIDTH-1:0]     target_q, target_d;
  logic [WIDTH-1:0]     step_q, step_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 update_tick;

  logic [WIDTH:0] duty_x, target_x, step_x, ramp_next;

  pwm_period_timer #(
    .WIDTH     (WIDTH),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (accept),
    .div_l       (div_q),
    .period_tick (period_tick),
    .update_tick (update_tick)
  );

  assign duty_x   = {1'b0, duty_q};
  assign target_x = {1'b0, target_q};
  assign step_x   = {1'b0, step_q};

  // One extra bit keeps the sum and the clamp limit from wrapping, so no overshoot.
  always_comb begin
    ramp_next = target_x;
    if (target_q > duty_q) begin
      if (duty_x + step_x < target_x) begin
        ramp_next = duty_x + step_x;
      end
    end else if (duty_x >= target_x + step_x) begin
      ramp_next = duty_x - step_x;
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    step_d   = step_q;
    div_d    = div_q;
    done_d   = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd.cmd_valid) begin
          accept   = 1'b1;
          target_d = cmd.cmd_target;
          step_d   = (cmd.cmd_step == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : cmd.cmd_step;
          div_d    = cmd.cmd_div;
          if (cmd.cmd_target == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = StRamp;
          end
        end
      end
      StRamp: begin
        if (abort) begin
          state_d = StIdle;
        end else if (update_tick) begin
          duty_d = ramp_next[WIDTH-1:0];
          if (ramp_next == target_x) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      duty_q   <= '0;
      target_q <= '0;
      step_q   <= '0;
      div_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
      div_q    <= div_d;
      done_q   <= done_d;
    end
  end

  assign cmd.cmd_ready = (state_q == StIdle);
  assign duty          = duty_q;
  assign busy          = (state_q == StRamp);
  assign done          = done_q;

endmodule

// File: tb/tb_pwm_fader.sv
// Directed and randomized checks of pwm_fader against a clamped-ramp arithmetic model.
module tb_pwm_fader;

  localparam int W   = 8;
  localparam int DW  = 16;
  localparam int PER = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] duty;
  logic         busy, done, period_tick;

  pwm_fader_if #(.WIDTH(W), .DIV_WIDTH(DW)) cmd_if ();

  pwm_fader #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .abort       (abort),
    .duty        (duty),
    .busy        (busy),
    .done        (done),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; its value modulo PER is where the PWM period stands.
  int unsigned ncyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) ncyc <= 0;
    else      ncyc <= ncyc + 1;
  end

  int checks = 0;
  int errors = 0;
  int m_duty, m_target, m_step, m_div;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_next(input int d, input int t, input int s);
    if (t > d) return (d + s >= t) ? t : d + s;
    return (d - s <= t) ? t : d - s;
  endfunction

  // Leaves the bench at the negedge just before a period-ending clock edge.
  task automatic goto_tick_edge();
    @(negedge clk);
    while (ncyc % PER != PER - 1) begin
      if (ncyc % PER == PER - 2) chk("tick_low", period_tick, 0);
      @(negedge clk);
    end
    chk("tick_high", period_tick, 1);
  endtask

  task automatic send_cmd(input int t, input int s, input int d, input bit with_abort);
    logic [31:0] tv, sv, dv;
    tv = t; sv = s; dv = d;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = tv[W-1:0];
    cmd_if.cmd_step   = sv[W-1:0];
    cmd_if.cmd_div    = dv[DW-1:0];
    abort             = with_abort;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    abort            = 1'b0;
    m_target = t;
    m_step   = (s == 0) ? 1 : s;
    m_div    = d;
    chk("accept_duty", duty, m_duty);
    if (t == m_duty) begin
      chk("same_done", done, 1);
      chk("same_busy", busy, 0);
      chk("same_ready", cmd_if.cmd_ready, 1);
      @(posedge clk);
      #1;
      chk("same_done_clr", done, 0);
      chk("same_busy_low", busy, 0);
    end else begin
      chk("accept_busy", busy, 1);
      chk("accept_ready", cmd_if.cmd_ready, 0);
      chk("accept_done", done, 0);
    end
  endtask

  // Follows the ramp tick by tick; abort_after >= 0 aborts once that many steps have landed.
  task automatic follow_ramp(input int abort_after);
    int n = 0;
    while (m_duty != m_target) begin
      if (n == abort_after) begin
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", cmd_if.cmd_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_duty", duty, m_duty);
        goto_tick_edge();
        @(posedge clk);
        #1;
        chk("abort_frozen", duty, m_duty);
        chk("abort_no_done", done, 0);
        return;
      end
      for (int j = 0; j <= m_div; j++) begin
        goto_tick_edge();
        chk("duty_hold", duty, m_duty);
        chk("ready_held_off", cmd_if.cmd_ready, 0);
        @(posedge clk);
        #1;
      end
      m_duty = model_next(m_duty, m_target, m_step);
      n++;
      chk("duty_step", duty, m_duty);
      if (m_duty == m_target) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_ready", cmd_if.cmd_ready, 1);
        @(posedge clk);
        #1;
        chk("done_clear", done, 0);
      end else begin
        chk("mid_done", done, 0);
        chk("mid_busy", busy, 1);
      end
    end
  endtask

  initial begin
    int t, s, d, ab;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_target = '0;
    cmd_if.cmd_step   = '0;
    cmd_if.cmd_div    = '0;
    m_duty = 0;
    #12;
    chk("rst_duty", duty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_if.cmd_ready, 1);
    chk("rst_tick", period_tick, 0);
    @(negedge clk);
    rst = 1'b1;

    // Up ramp, then clamp on the way up and down with no underflow.
    send_cmd(64, 16, 0, 0);  follow_ramp(-1);
    send_cmd(70, 16, 0, 0);  follow_ramp(-1);
    send_cmd(0, 30, 0, 0);   follow_ramp(-1);

    // Abort after three steps holds duty at 30.
    send_cmd(200, 10, 0, 0); follow_ramp(3);
    chk("abort_at_30", duty, 30);
    send_cmd(0, 255, 0, 0);  follow_ramp(-1);

    // Divider of 2, issued together with an abort that idle must ignore.
    send_cmd(8, 4, 2, 1);    follow_ramp(-1);

    // Target equal to present duty.
    send_cmd(8, 9, 0, 0);

    // cmd_valid held through a ramp; the second command waits for cmd_ready.
    @(negedge clk);
    chk("held_ready0", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 8'd28;
    cmd_if.cmd_step   = 8'd20;
    cmd_if.cmd_div    = '0;
    @(posedge clk);
    #1;
    m_target = 28; m_step = 20; m_div = 0;
    cmd_if.cmd_target = 8'd5;
    cmd_if.cmd_step   = 8'd7;
    chk("held_busy_a", busy, 1);
    follow_ramp(-1);
    chk("held_busy_b", busy, 1);
    chk("held_ready_b", cmd_if.cmd_ready, 0);
    chk("held_duty_b", duty, 28);
    cmd_if.cmd_valid = 1'b0;
    m_target = 5; m_step = 7; m_div = 0;
    follow_ramp(-1);

    // Zero step behaves as one.
    send_cmd(m_duty + 3, 0, 1, 0); follow_ramp(-1);

    for (int i = 0; i < 4; i++) begin
      t  = $urandom_range(0, 255);
      s  = $urandom_range(30, 120);
      d  = $urandom_range(0, 1);
      ab = ($urandom_range(0, 3) == 0) ? 1 : -1;
      send_cmd(t, s, d, 0);
      follow_ramp(ab);
    end

    // Reset part-way through a long ramp.
    send_cmd((m_duty < 128) ? 255 : 0, 10, 0, 0);
    goto_tick_edge();
    @(posedge clk);
    #1;
    m_duty = model_next(m_duty, m_target, m_step);
    chk("rst_pre_duty", duty, m_duty);
    repeat (40) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_duty", duty, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_if.cmd_ready, 1);
    chk("midrst_done", done, 0);
    m_duty = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    while (ncyc != PER - 2) @(negedge clk);
    chk("post_rst_tick_low", period_tick, 0);
    @(negedge clk);
    chk("post_rst_tick_high", period_tick, 1);
    @(posedge clk);
    #1;
    chk("post_rst_duty", duty, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_tick_clr", period_tick, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
